i2c_target_responder: RTL and testbench

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

---
 rtl/i2c_target_responder_pkg.sv | 20 ++
 rtl/i2c_line_sync.sv | 40 ++++
 rtl/i2c_target_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_responder_pkg.sv
// Shared definitions for the I2C target responder: FSM state encoding and
// bit positions inside status_signals.
package i2c_target_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_RW    = 1;
    localparam int STAT_MATCH = 2;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one raw bus line, with an optional 3-sample
// majority filter enabled by the I2C_GLITCH_FILTER_EN macro.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);

    // Reset to 1 so a freshly reset target sees an idle (released) bus.
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    // A level change must persist for two samples before it is passed on.
    assign line_o = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & hist_q[2]) |
                    (hist_q[1] & hist_q[2]);
`else
    assign line_o = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target answering at TARGET_ADDR: accepts write bytes on rx_data and
// returns tx_data on reads. Optional input glitch filter: I2C_GLITCH_FILTER_EN.
module i2c_target_responder
    import i2c_target_responder_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] status_signals
);

    logic scl, sda;
    logic scl_q, sda_q;

    i2c_line_sync u_scl_sync (.clk(clk), .rst_n(rst_n), .line_i(scl_i), .line_o(scl));
    i2c_line_sync u_sda_sync (.clk(clk), .rst_n(rst_n), .line_i(sda_i), .line_o(sda));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       match_q, match_d;
    logic       phase_q, phase_d;
    logic       oe_d;
    logic [7:0] rx_data_d;
    logic       rx_valid_d, tx_load_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            tx_shift_q <= 8'd0;
            rw_q       <= 1'b0;
            match_q    <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_load    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            match_q    <= match_d;
            phase_q    <= phase_d;
            sda_oe     <= oe_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            tx_load    <= tx_load_d;
        end
    end

    // phase_q marks the second half of an ACK slot: in ADDR_ACK/WR_ACK it is
    // set once ACK is driven, in RD_ACK once the controller's ACK was sampled.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        match_d    = match_q;
        phase_d    = phase_q;
        oe_d       = sda_oe;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        if (stop_det) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            match_d   = 1'b0;
            rw_d      = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            oe_d      = 1'b0;
            match_d   = 1'b0;
            rw_d      = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (shift_q == TARGET_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                match_d = 1'b1;
                                rw_d    = sda;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (rw_q) begin
                                state_d    = ST_RD_BYTE;
                                tx_shift_d = tx_data;
                                tx_load_d  = 1'b1;
                                oe_d       = ~tx_data[7];
                            end else begin
                                state_d = ST_WR_BYTE;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q, sda};
                            rx_valid_d = 1'b1;
                            state_d    = ST_WR_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            state_d = ST_WR_BYTE;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    // Bit 7 went out on entry; each fall presents the next bit.
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            state_d = ST_RD_ACK;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], tx_shift_q[7]};
                            oe_d       = ~tx_shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = ST_IGNORE;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d    = 1'b0;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_RD_BYTE;
                        tx_shift_d = tx_data;
                        tx_load_d  = 1'b1;
                        oe_d       = ~tx_data[7];
                    end
                end
                ST_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        status_signals             = 8'h00;
        status_signals[STAT_BUSY]  = (state_q != ST_IDLE);
        status_signals[STAT_RW]    = rw_q;
        status_signals[STAT_MATCH] = match_q;
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bus-controller model drives
// SCL/SDA as an open-drain pair and each observation is checked inline.
module tb_i2c_target_responder;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_ctrl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] status_signals;

    int checks = 0;
    int errors = 0;
    int rx_pulses = 0;
    int tx_pulses = 0;
    int oe_hits = 0;
    int oe_viol = 0;
    logic oe_prev = 1'b0;

    assign sda_bus = sda_ctrl & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_responder #(.TARGET_ADDR(7'h42)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scl_i(scl_ctrl),
        .sda_i(sda_bus),
        .sda_oe(sda_oe),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .status_signals(status_signals)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_pulses <= rx_pulses + 1;
        if (tx_load) tx_pulses <= tx_pulses + 1;
        if (sda_oe) oe_hits <= oe_hits + 1;
        if (rst_n && scl_ctrl && (sda_oe !== oe_prev)) oe_viol <= oe_viol + 1;
        oe_prev <= sda_oe;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b0; wait_clk(Q);
        scl_ctrl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_rep_start();
        sda_ctrl = 1'b1; wait_clk(Q);
        scl_ctrl = 1'b1; wait_clk(Q);
        sda_ctrl = 1'b0; wait_clk(Q);
        scl_ctrl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; wait_clk(Q);
        scl_ctrl = 1'b1; wait_clk(Q);
        sda_ctrl = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_ctrl = b;    wait_clk(Q);
        scl_ctrl = 1'b1; wait_clk(2 * Q);
        scl_ctrl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_ctrl = 1'b1; wait_clk(Q);
        scl_ctrl = 1'b1; wait_clk(Q);
        acked = ~sda_bus;
        wait_clk(Q);
        scl_ctrl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) begin
            sda_ctrl = 1'b1; wait_clk(Q);
            scl_ctrl = 1'b1; wait_clk(Q);
            data[i] = sda_bus;
            wait_clk(Q);
            scl_ctrl = 1'b0; wait_clk(Q);
        end
        sda_ctrl = ~send_ack; wait_clk(Q);
        scl_ctrl = 1'b1;      wait_clk(2 * Q);
        scl_ctrl = 1'b0;      wait_clk(Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx_snap, tx_snap, oe_snap;

        // Reset state
        wait_clk(4);
        check("reset_sda_oe", 32'(sda_oe), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_tx_load", 32'(tx_load), 32'h0);
        check("reset_status", 32'(status_signals), 32'h00);
        rst_n = 1'b1;
        wait_clk(4 * Q);

        // Write 0x84 then 0x5A, then STOP
        rx_snap = rx_pulses;
        i2c_start();
        write_byte(8'h84, ack);
        check("wr_addr_ack", 32'(ack), 32'h1);
        check("wr_status", 32'(status_signals), 32'h05);
        write_byte(8'h5A, ack);
        check("wr_data_ack", 32'(ack), 32'h1);
        check("wr_rx_data", 32'(rx_data), 32'h5A);
        check("wr_rx_pulses", 32'(rx_pulses - rx_snap), 32'd1);
        i2c_stop();
        wait_clk(Q);
        check("wr_status_after_stop", 32'(status_signals), 32'h00);
        check("wr_oe_after_stop", 32'(sda_oe), 32'h0);

        // Read 0x85: ACK first byte, NACK second
        tx_data = 8'hC3;
        tx_snap = tx_pulses;
        i2c_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", 32'(ack), 32'h1);
        check("rd_status", 32'(status_signals), 32'h07);
        tx_data = 8'h3C;
        read_byte(1'b1, rd);
        check("rd_byte0", 32'(rd), 32'hC3);
        read_byte(1'b0, rd);
        check("rd_byte1", 32'(rd), 32'h3C);
        check("rd_tx_pulses", 32'(tx_pulses - tx_snap), 32'd2);
        check("rd_oe_after_nack", 32'(sda_oe), 32'h0);
        check("rd_status_ignore", 32'(status_signals), 32'h07);
        i2c_stop();
        wait_clk(Q);
        check("rd_status_after_stop", 32'(status_signals), 32'h00);

        // Foreign address 0x43: target stays off the bus
        rx_snap = rx_pulses;
        oe_snap = oe_hits;
        i2c_start();
        write_byte(8'h86, ack);
        check("nomatch_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack);
        check("nomatch_data_ack", 32'(ack), 32'h0);
        check("nomatch_status", 32'(status_signals), 32'h01);
        i2c_stop();
        check("nomatch_oe_hits", 32'(oe_hits - oe_snap), 32'd0);
        check("nomatch_rx_pulses", 32'(rx_pulses - rx_snap), 32'd0);

        // Partial write byte aborted by a repeated START into a read
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'h84, ack);
        check("rs_wr_addr_ack", 32'(ack), 32'h1);
        rx_snap = rx_pulses;
        tx_snap = tx_pulses;
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_rep_start();
        write_byte(8'h85, ack);
        check("rs_rd_addr_ack", 32'(ack), 32'h1);
        check("rs_status", 32'(status_signals), 32'h07);
        read_byte(1'b0, rd);
        check("rs_rd_byte", 32'(rd), 32'h96);
        check("rs_rx_pulses", 32'(rx_pulses - rx_snap), 32'd0);
        check("rs_tx_pulses", 32'(tx_pulses - tx_snap), 32'd1);
        i2c_stop();

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h84 >> i));
        check("rst_oe_before", 32'(sda_oe), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_oe_immediate", 32'(sda_oe), 32'h0);
        check("rst_status", 32'(status_signals), 32'h00);
        wait_clk(2);
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        wait_clk(Q);
        rst_n = 1'b1;
        wait_clk(Q);
        check("rst_release_status", 32'(status_signals), 32'h00);
        rx_snap = rx_pulses;
        i2c_start();
        write_byte(8'h84, ack);
        check("post_rst_addr_ack", 32'(ack), 32'h1);
        write_byte(8'hA7, ack);
        check("post_rst_data_ack", 32'(ack), 32'h1);
        check("post_rst_rx_data", 32'(rx_data), 32'hA7);
        check("post_rst_rx_pulses", 32'(rx_pulses - rx_snap), 32'd1);
        i2c_stop();
        wait_clk(Q);

`ifdef I2C_GLITCH_FILTER_EN
        // One-clk SDA low glitch with SCL high must not look like START
        sda_ctrl = 1'b0;
        wait_clk(1);
        sda_ctrl = 1'b1;
        wait_clk(2 * Q);
        check("glitch_status", 32'(status_signals), 32'h00);
`endif

        check("oe_change_while_scl_high", 32'(oe_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
